// File: rtl/nav_arbiter.sv
// Arbitrates the shared navigation datapath between the command processor and the maze solver.
// Latches the winning heading, forwards start pulses, routes completion to the owner, and guards against stuck operations with a watchdog.
module nav_arbiter #(
  parameter int TMO_W   = 20,
  parameter int TMO_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_md,
  input  logic        cmd_strt_hdng,
  input  logic        cmd_strt_mv,
  input  logic [11:0] cmd_dsrd_hdng,
  input  logic        slv_strt_hdng,
  input  logic        slv_strt_mv,
  input  logic [11:0] slv_dsrd_hdng,
  input  logic        nav_mv_cmplt,
  input  logic        clr_fault,
  output logic        nav_strt_hdng,
  output logic        nav_strt_mv,
  output logic [11:0] nav_dsrd_hdng,
  output logic        cmd_mv_cmplt,
  output logic        slv_mv_cmplt,
  output logic        busy,
  output logic        req_drop,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HDNG_BUSY = 2'd1,
    MV_BUSY   = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] WDOG_ONE = TMO_W'(1);

  state_t           state_r;
  logic             owner_r;   // 1 = command processor, 0 = solver
  logic [TMO_W-1:0] wdog_r;

  logic        sel_hdng_s;
  logic        sel_mv_s;
  logic [11:0] sel_dsrd_s;
  logic        unsel_any_s;
  logic        any_strt_s;

  // Pick the requester that cmd_md currently grants and flag requests from the other one.
  always_comb begin
    sel_hdng_s  = 1'b0;
    sel_mv_s    = 1'b0;
    sel_dsrd_s  = 12'h000;
    unsel_any_s = 1'b0;
    any_strt_s  = cmd_strt_hdng | cmd_strt_mv | slv_strt_hdng | slv_strt_mv;
    if (cmd_md) begin
      sel_hdng_s  = cmd_strt_hdng;
      sel_mv_s    = cmd_strt_mv;
      sel_dsrd_s  = cmd_dsrd_hdng;
      unsel_any_s = slv_strt_hdng | slv_strt_mv;
    end else begin
      sel_hdng_s  = slv_strt_hdng;
      sel_mv_s    = slv_strt_mv;
      sel_dsrd_s  = slv_dsrd_hdng;
      unsel_any_s = cmd_strt_hdng | cmd_strt_mv;
    end
  end

  // Operation FSM with watchdog; every output is a flop so pulses appear one cycle after their cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      owner_r       <= 1'b0;
      wdog_r        <= '0;
      nav_strt_hdng <= 1'b0;
      nav_strt_mv   <= 1'b0;
      nav_dsrd_hdng <= 12'h000;
      cmd_mv_cmplt  <= 1'b0;
      slv_mv_cmplt  <= 1'b0;
      busy          <= 1'b0;
      req_drop      <= 1'b0;
      fault         <= 1'b0;
    end else begin
      nav_strt_hdng <= 1'b0;
      nav_strt_mv   <= 1'b0;
      cmd_mv_cmplt  <= 1'b0;
      slv_mv_cmplt  <= 1'b0;
      req_drop      <= 1'b0;
      case (state_r)
        IDLE: begin
          // A simultaneous move from the granted source loses to the heading change.
          req_drop <= unsel_any_s | (sel_hdng_s & sel_mv_s);
          if (sel_hdng_s) begin
            nav_strt_hdng <= 1'b1;
            nav_dsrd_hdng <= sel_dsrd_s;
            owner_r       <= cmd_md;
            wdog_r        <= '0;
            busy          <= 1'b1;
            state_r       <= HDNG_BUSY;
          end else if (sel_mv_s) begin
            nav_strt_mv <= 1'b1;
            owner_r     <= cmd_md;
            wdog_r      <= '0;
            busy        <= 1'b1;
            state_r     <= MV_BUSY;
          end else begin
            busy <= 1'b0;
          end
        end
        HDNG_BUSY, MV_BUSY: begin
          req_drop <= any_strt_s;
          if (nav_mv_cmplt) begin
            cmd_mv_cmplt <= owner_r;
            slv_mv_cmplt <= ~owner_r;
            busy         <= 1'b0;
            state_r      <= IDLE;
          end else if (wdog_r == TMO_LAST) begin
            fault   <= 1'b1;
            busy    <= 1'b0;
            state_r <= FAULT;
          end else begin
            wdog_r <= wdog_r + WDOG_ONE;
          end
        end
        FAULT: begin
          req_drop <= any_strt_s;
          busy     <= 1'b0;
          if (clr_fault) begin
            fault   <= 1'b0;
            state_r <= IDLE;
          end else begin
            fault <= 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
